// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler
//   Shares one combinational ALU between two command requesters. Commands are
//   accepted one at a time with round-robin arbitration on ties, the operands
//   are registered onto the ALU inputs, the ALU outputs are captured one cycle
//   later, and a tagged response is presented on a valid/ready interface.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   reqN_valid/_ready           command handshake for requester N (N = 0, 1)
//   reqN_op/_a/_b               command opcode and operands
//   alu_opcode/_a/_b            registered ALU inputs
//   alu_result/_flagC/_flagZ    ALU outputs
//   rsp_valid/_ready            response handshake
//   rsp_id                      requester that issued the command
//   rsp_result/_flagC/_flagZ    captured ALU outputs (carry kept only for ADD/SUB)
//   rsp_err                     divide-by-zero trap indication
//   busy                        high while a command is in flight
//
// Build option
//   ALU_DIV0_TRAP_EN  when defined, DIV with b == 0 bypasses the ALU and
//                     returns an all-ones result with rsp_err set.
`timescale 1ns/1ps

module alu_req_scheduler #(
  parameter int unsigned W   = 32,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic [OPW-1:0] alu_opcode,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_flagC,
  input  logic           alu_flagZ,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_result,
  output logic           rsp_flagC,
  output logic           rsp_flagZ,
  output logic           rsp_err,
  output logic           busy
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           last_grant;
  logic           grant_any;
  logic           grant_id;
  logic           accept;
  logic [OPW-1:0] sel_op;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           trap;

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
  end

  assign accept     = (state == IDLE) && grant_any;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept &&  grant_id;

  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;

`ifdef ALU_DIV0_TRAP_EN
  localparam logic [OPW-1:0] OP_DIV = OPW'(3);
  assign trap = (sel_op == OP_DIV) && (sel_b == '0);
`else
  assign trap = 1'b0;
`endif

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = trap ? RESP : EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      last_grant <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flagC  <= 1'b0;
      rsp_flagZ  <= 1'b0;
    end else begin
      if (accept) begin
        alu_opcode <= sel_op;
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        rsp_id     <= grant_id;
        last_grant <= grant_id;
        // A trapped divide skips EXEC, so its response is formed here.
        if (trap) begin
          rsp_result <= '1;
          rsp_flagC  <= 1'b0;
          rsp_flagZ  <= 1'b0;
        end
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_flagZ  <= alu_flagZ;
        // The ALU leaves its carry stale on non-arithmetic ops.
        rsp_flagC  <= ((alu_opcode == OP_ADD) || (alu_opcode == OP_SUB)) && alu_flagC;
      end
    end
  end

`ifdef ALU_DIV0_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rsp_err <= 1'b0;
    else if (accept) rsp_err <= trap;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
